// File: rtl/hex_disp_pkg.sv
// Shared types, register map and segment encoding for the seven-segment display encoder.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_ENCODE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_SEG    = 2'd3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low pattern for one hex digit; bit 7 (decimal point) is always off.
    function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational 4-bit to active-low seven-segment encoder.
module hex_seg_lut
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = nibble_to_seg(nibble);

endmodule

// File: rtl/hex_bcd_encoder.sv
// Avalon-MM slave converting a 16-bit value to four hex or decimal seven-segment digits,
// with leading-zero blanking, overflow dashes and per-digit blink.
module hex_bcd_encoder
    import hex_disp_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] seg_out
);

    localparam int PRESC_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_DIV - 1);

    state_t              state_q, state_d;
    logic [15:0]         value_q, value_d;
    logic                dec_q, dec_d;
    logic                lzb_q, lzb_d;
    logic [3:0]          mask_q, mask_d;
    logic                cdec_q, cdec_d;
    logic                clzb_q, clzb_d;
    logic [19:0]         bcd_q, bcd_d;
    logic [15:0]         bin_q, bin_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         seg_reg_q, seg_reg_d;
    logic                ovf_q, ovf_d;
    logic                dropped_q, dropped_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                phase_q, phase_d;

    logic        wr;
    logic        busy;
    logic [15:0] lut_in;
    logic [31:0] lut_word;
    logic [31:0] enc_word;
    logic        enc_ovf;
    logic        leading;
    logic [17:0] unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign busy         = (state_q != ST_IDLE);
    assign unused_wdata = {writedata[31:16], writedata[3:2]};

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digit sources for the four LUTs: BCD result in decimal mode, raw value in hex mode.
    always_comb begin
        lut_in = cdec_q ? bcd_q[15:0] : bin_q;
    end

    for (genvar k = 0; k < 4; k++) begin : g_lut
        hex_seg_lut u_lut (
            .nibble (lut_in[4*k +: 4]),
            .seg    (lut_word[8*k +: 8])
        );
    end

    // Final display word: overflow dashes and leading-zero blanking (decimal only).
    always_comb begin
        enc_word = lut_word;
        enc_ovf  = 1'b0;
        leading  = cdec_q & clzb_q;
        if (cdec_q && (bcd_q[19:16] != 4'd0)) begin
            enc_word = {4{SEG_DASH}};
            enc_ovf  = 1'b1;
        end else begin
            for (int k = 3; k >= 1; k--) begin
                if (leading && (bcd_q[4*k +: 4] == 4'd0)) begin
                    enc_word[8*k +: 8] = SEG_BLANK;
                end else begin
                    leading = 1'b0;
                end
            end
        end
    end

    // Register file writes, conversion FSM, double-dabble datapath and blink prescaler.
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        dec_d     = dec_q;
        lzb_d     = lzb_q;
        mask_d    = mask_q;
        cdec_d    = cdec_q;
        clzb_d    = clzb_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        seg_reg_d = seg_reg_q;
        ovf_d     = ovf_q;
        dropped_d = dropped_q;
        presc_d   = presc_q + 1'b1;
        phase_d   = phase_q;

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end

        if (wr) begin
            case (address)
                ADDR_VALUE: begin
                    if (!busy) begin
                        value_d = writedata[15:0];
                        state_d = ST_LOAD;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
                ADDR_CTRL: begin
                    dec_d  = writedata[0];
                    lzb_d  = writedata[1];
                    mask_d = writedata[7:4];
                end
                ADDR_STATUS: dropped_d = 1'b0;
                default: ;
            endcase
        end

        case (state_q)
            ST_LOAD: begin
                bcd_d   = '0;
                cnt_d   = '0;
                bin_d   = value_q;
                cdec_d  = dec_q;
                clzb_d  = lzb_q;
                state_d = dec_q ? ST_SHIFT : ST_ENCODE;
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = ST_ENCODE;
            end
            ST_ENCODE: begin
                seg_reg_d = enc_word;
                ovf_d     = enc_ovf;
                state_d   = ST_IDLE;
            end
            default: ;
        endcase
    end

    // State and register update; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            dec_q     <= 1'b0;
            lzb_q     <= 1'b0;
            mask_q    <= '0;
            cdec_q    <= 1'b0;
            clzb_q    <= 1'b0;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            seg_reg_q <= '1;
            ovf_q     <= 1'b0;
            dropped_q <= 1'b0;
            presc_q   <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            dec_q     <= dec_d;
            lzb_q     <= lzb_d;
            mask_q    <= mask_d;
            cdec_q    <= cdec_d;
            clzb_q    <= clzb_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            seg_reg_q <= seg_reg_d;
            ovf_q     <= ovf_d;
            dropped_q <= dropped_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
        end
    end

    // Blink overlay: masked digits go dark during the blink-off phase.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            seg_out[8*k +: 8] = (phase_q && mask_q[k]) ? SEG_BLANK : seg_reg_q[8*k +: 8];
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_VALUE:  readdata = {16'h0, value_q};
            ADDR_CTRL:   readdata = {24'h0, mask_q, 2'b00, lzb_q, dec_q};
            ADDR_STATUS: readdata = {29'h0, dropped_q, ovf_q, busy};
            default:     readdata = seg_reg_q;
        endcase
    end

endmodule
